// File: rtl/axi_tdd_pkg.sv
// Shared TDD definitions: controller state encoding used by the frame
// controller and the downstream channel comparators.
package axi_tdd_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      WAITING = 2'd2,
      RUNNING = 2'd3
   } state_t;

endpackage

// File: rtl/axi_tdd_frame_ctrl_if.sv
// Control/status bundle between the TDD sync generator side and the frame
// controller; the controller attaches through the slave modport.
interface axi_tdd_frame_ctrl_if #(
   parameter int unsigned REGISTER_WIDTH    = 32,
   parameter int unsigned BURST_COUNT_WIDTH = 32
);

   logic                         tdd_enable;
   logic                         tdd_sync;
   logic                         tdd_sync_rst;
   logic [REGISTER_WIDTH-1:0]    asy_tdd_frame_length;
   logic [REGISTER_WIDTH-1:0]    asy_tdd_startup_delay;
   logic [BURST_COUNT_WIDTH-1:0] asy_tdd_burst_count;

   logic [REGISTER_WIDTH-1:0]    tdd_counter;
   logic [1:0]                   tdd_cstate;
   logic                         tdd_tpulse;
   logic                         tdd_endof_frame;
   logic                         tdd_endof_burst;

   modport master (
      output tdd_enable, tdd_sync, tdd_sync_rst,
             asy_tdd_frame_length, asy_tdd_startup_delay, asy_tdd_burst_count,
      input  tdd_counter, tdd_cstate, tdd_tpulse, tdd_endof_frame, tdd_endof_burst
   );

   modport slave (
      input  tdd_enable, tdd_sync, tdd_sync_rst,
             asy_tdd_frame_length, asy_tdd_startup_delay, asy_tdd_burst_count,
      output tdd_counter, tdd_cstate, tdd_tpulse, tdd_endof_frame, tdd_endof_burst
   );

endinterface

// File: rtl/axi_tdd_frame_ctrl.sv
// TDD frame timing controller: after an accepted sync, waits the startup
// delay and then runs a burst of fixed-length frames with registered markers.
module axi_tdd_frame_ctrl
   import axi_tdd_pkg::*;
#(
   parameter int unsigned REGISTER_WIDTH    = 32,
   parameter int unsigned BURST_COUNT_WIDTH = 32
) (
   input logic                 clk,
   input logic                 rst,
   axi_tdd_frame_ctrl_if.slave tdd
);

   localparam logic [REGISTER_WIDTH-1:0]    RW_ONE = REGISTER_WIDTH'(1);
   localparam logic [BURST_COUNT_WIDTH-1:0] BW_ONE = BURST_COUNT_WIDTH'(1);

   state_t                       state_q, state_d;
   logic [REGISTER_WIDTH-1:0]    cnt_q, cnt_d;
   logic [BURST_COUNT_WIDTH-1:0] idx_q, idx_d;

   logic [REGISTER_WIDTH-1:0]    frame_term_q;
   logic [REGISTER_WIDTH-1:0]    delay_term_q;
   logic                         delay_zero_q;
   logic [BURST_COUNT_WIDTH-1:0] burst_term_q;
   logic                         burst_inf_q;

   logic tpulse_q, tpulse_d;
   logic eof_q, eof_d;
   logic eob_q, eob_d;
   logic resync;

   // Terminal values are derived while IDLE so the run-time compares are plain equalities.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_term_q <= '0;
         delay_term_q <= '0;
         delay_zero_q <= 1'b0;
         burst_term_q <= '0;
         burst_inf_q  <= 1'b0;
      end else if (state_q == IDLE) begin
         frame_term_q <= (tdd.asy_tdd_frame_length == '0) ? '0
                         : tdd.asy_tdd_frame_length - RW_ONE;
         delay_term_q <= tdd.asy_tdd_startup_delay - RW_ONE;
         delay_zero_q <= (tdd.asy_tdd_startup_delay == '0);
         burst_term_q <= tdd.asy_tdd_burst_count - BW_ONE;
         burst_inf_q  <= (tdd.asy_tdd_burst_count == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         tpulse_q <= 1'b0;
         eof_q    <= 1'b0;
         eob_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         tpulse_q <= tpulse_d;
         eof_q    <= eof_d;
         eob_q    <= eob_d;
      end
   end

   assign resync = tdd.tdd_sync && tdd.tdd_sync_rst &&
                   ((state_q == WAITING) || (state_q == RUNNING));

   // eof_q/eob_q already encode "RUNNING at frame terminal" for the current cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;

      if (!tdd.tdd_enable) begin
         state_d = IDLE;
         cnt_d   = '0;
         idx_d   = '0;
      end else if (resync) begin
         state_d = delay_zero_q ? RUNNING : WAITING;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = ARMED;
               cnt_d   = '0;
               idx_d   = '0;
            end
            ARMED: begin
               cnt_d = '0;
               if (tdd.tdd_sync) state_d = delay_zero_q ? RUNNING : WAITING;
            end
            WAITING: begin
               if (cnt_q == delay_term_q) begin
                  state_d = RUNNING;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + RW_ONE;
               end
            end
            RUNNING: begin
               if (eof_q) begin
                  cnt_d = '0;
                  if (eob_q) begin
                     state_d = ARMED;
                     idx_d   = '0;
                  end else begin
                     idx_d = idx_q + BW_ONE;
                  end
               end else begin
                  cnt_d = cnt_q + RW_ONE;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      tpulse_d = (state_d == RUNNING) && (cnt_d == '0);
      eof_d    = (state_d == RUNNING) && (cnt_d == frame_term_q);
      eob_d    = eof_d && !burst_inf_q && (idx_d == burst_term_q);
   end

   assign tdd.tdd_counter     = cnt_q;
   assign tdd.tdd_cstate      = state_q;
   assign tdd.tdd_tpulse      = tpulse_q;
   assign tdd.tdd_endof_frame = eof_q;
   assign tdd.tdd_endof_burst = eob_q;

endmodule

// File: doc/axi_tdd_frame_ctrl.md
# axi_tdd_frame_ctrl

Frame timing controller that consumes the one-cycle sync pulse produced by the TDD sync generator. On each accepted sync it waits a startup delay, then runs a burst of fixed-length frames. It drives the frame counter, controller state and frame/burst markers used by the downstream TDD channel comparators. It sits directly between the sync generator output and the per-channel on/off logic, in the same clock domain.

## Interface

Parameters:
- REGISTER_WIDTH, 32: width of frame length, startup delay and frame counter.
- BURST_COUNT_WIDTH, 32: width of burst count and internal frame index.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  core clock; all logic on its rising edge.
- rst  input  1  synchronous active-high reset.
- tdd_enable  input  1  global enable; low forces IDLE.
- tdd_sync  input  1  single-cycle sync pulse from the sync generator.
- tdd_sync_rst  input  1  when high, a sync received while RUNNING or WAITING restarts the burst.
- asy_tdd_frame_length  input  REGISTER_WIDTH  frame length in clk cycles; 0 is treated as 1.
- asy_tdd_startup_delay  input  REGISTER_WIDTH  cycles between sync and first frame; 0 means no delay.
- asy_tdd_burst_count  input  BURST_COUNT_WIDTH  frames per burst; 0 means infinite.
- tdd_counter  output  REGISTER_WIDTH  current delay or frame cycle count.
- tdd_cstate  output  2  controller state: IDLE=0, ARMED=1, WAITING=2, RUNNING=3.
- tdd_tpulse  output  1  high in the first cycle of every frame.
- tdd_endof_frame  output  1  high in the last cycle of every frame.
- tdd_endof_burst  output  1  high in the last cycle of the last frame of a finite burst.

## Operation

- The asy_* inputs are captured into internal registers on every cycle while the state is IDLE. They are held constant in all other states.
- Terminal values:
  - frame terminal FT = (L==0) ? 0 : L-1.
  - delay terminal DT = D-1.
  - All compares are unsigned, at full width, with no wrap-around.
- IDLE: counter is 0. If tdd_enable is high, go to ARMED next cycle.
- ARMED: counter is 0; wait for tdd_sync.
  - tdd_sync with D≠0: go to WAITING.
  - tdd_sync with D==0: go to RUNNING.
- WAITING: counter increments from 0. When counter==DT, go to RUNNING and set counter to 0.
- RUNNING: counter increments from 0. When counter==FT, assert end of frame, set counter to 0 and advance the frame index.
  - If the burst count B≠0 and the frame index is B-1: assert end of burst, go to ARMED and clear the frame index.
  - If B==0: run indefinitely.
- Sync in WAITING or RUNNING:
  - tdd_sync_rst=1: counter and frame index clear, and the state re-enters WAITING (D≠0) or RUNNING (D==0). This takes priority over the terminal-count transition in the same cycle.
  - tdd_sync_rst=0: the sync is ignored.
- Sync in IDLE is ignored.
- tdd_enable low in any state: IDLE next cycle, counter and frame index set to 0. Enable low takes priority over sync and terminal events.
- rst takes priority over everything.

## Timing

- Reset values: tdd_cstate=IDLE, tdd_counter=0, tdd_tpulse=0, tdd_endof_frame=0, tdd_endof_burst=0, frame index 0, captured registers 0.
- All outputs are registered and cycle-aligned with tdd_counter/tdd_cstate:
  - tpulse is high when cstate==RUNNING and counter==0.
  - endof_frame is high when cstate==RUNNING and counter==FT.
  - endof_burst is high together with endof_frame on the final frame.
- Sync sampled high in cycle N, state ARMED:
  - D≠0: cstate=WAITING in cycles N+1..N+D, with counter 0..D-1. RUNNING starts at N+D+1 with counter=0 and tpulse=1.
  - D==0: RUNNING with tpulse at N+1.
- Enable rising in cycle N: ARMED at N+1. A sync at N+1 is accepted.
- L==1: tpulse and endof_frame are high together every RUNNING cycle.
- Back-to-back frames have no gap: FT is followed directly by counter 0 with tpulse.
- After end of burst, ARMED is entered the next cycle. A sync in that same cycle is accepted.

## Structure

- Add to the shared package axi_tdd_pkg:
  - typedef enum logic [1:0] state_t with IDLE, ARMED, WAITING, RUNNING.
  - Encodings fixed as above.
- Single module; no sub-module. Register capture, state machine, counter and flag logic are inline.
- Terminal values are precomputed in registers during IDLE, so the compare path is a single equality.

## Test plan

- Basic burst: L=4, D=3, B=2, sync once → WAITING for 3 cycles, then 8 RUNNING cycles. tpulse is high on counter 0 in both frames. endof_burst is high at the 8th RUNNING cycle, then ARMED.
- No delay, infinite burst: D=0, B=0, L=5, sync at N → RUNNING at N+1. tpulse every 5 cycles for 100 cycles; no endof_burst.
- Resync: L=10, D=0, tdd_sync_rst=1, second sync at counter=6 → counter 0 with tpulse next cycle. Repeat with tdd_sync_rst=0 → sync ignored and counter continues to 7.
- Enable drop mid-frame: RUNNING at counter=2, tdd_enable low → IDLE with counter 0 next cycle. asy_* changes are then captured.
- Boundary: L=0 and L=1 → tpulse and endof_frame high every RUNNING cycle. L=2^32-1 preloaded → endof_frame occurs at counter=2^32-2, with no wrap.
- Reset mid-operation: rst asserted in WAITING → all outputs at reset values next cycle. A sync during rst has no effect.
